// File: rtl/obstacle_spawner_if.sv
// Spawn handshake between obstacle_spawner (master) and the object manager (slave).
interface obstacle_spawner_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x;

  modport master (output spawn_valid, output spawn_x, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_x, output spawn_ready);
endinterface

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: waits a randomised number of frames, draws an X coordinate
// by rejection sampling the LFSR word, and presents it on a valid/ready handshake.
// Optional macro SPAWN_LEVEL_EN adds a level[2:0] input that shrinks the random
// part of the frame gap (reload = GAP_MIN + (rand LSBs >> level)).
module obstacle_spawner #(
  parameter int unsigned X_MAX         = 600,
  parameter int unsigned GAP_MIN       = 30,
  parameter int unsigned GAP_RAND_BITS = 6,
  parameter int unsigned MAX_RETRY     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_tick,
  input  logic [9:0]            rand_in,
`ifdef SPAWN_LEVEL_EN
  input  logic [2:0]            level,
`endif
  obstacle_spawner_if.master    spawn,
  output logic [7:0]            spawn_count
);

  localparam int unsigned GAP_W   = $clog2(GAP_MIN + (1 << GAP_RAND_BITS));
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, PRESENT} state_e;

  state_e               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [9:0]           x_q, x_d;
  logic                 valid_q, valid_d;
  logic [7:0]           count_q, count_d;

  logic [GAP_RAND_BITS-1:0] rand_gap_c;
  logic [GAP_W-1:0]         reload_c;
  logic                     in_range_c;
  logic                     accept_c;

  // Random part of the frame gap, optionally thinned by the game level.
`ifdef SPAWN_LEVEL_EN
  assign rand_gap_c = rand_in[GAP_RAND_BITS-1:0] >> level;
`else
  assign rand_gap_c = rand_in[GAP_RAND_BITS-1:0];
`endif

  assign reload_c   = GAP_W'(GAP_MIN) + GAP_W'(rand_gap_c);
  assign in_range_c = {1'b0, rand_in} < 11'(X_MAX);
  assign accept_c   = valid_q && spawn.spawn_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q   <= '0;
      retry_q <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      gap_q   <= gap_d;
      retry_q <= retry_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update; ticks only count while waiting.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    retry_d = retry_q;
    x_d     = x_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT;
          gap_d   = reload_c;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
          retry_d = '0;
        end else if (frame_tick) begin
          if (gap_q == '0) state_d = SAMPLE;
          else             gap_d   = gap_q - GAP_W'(1);
        end
      end
      SAMPLE: begin
        if (!enable) begin
          state_d = IDLE;
          retry_d = '0;
        end else if (in_range_c) begin
          x_d     = rand_in;
          valid_d = 1'b1;
          retry_d = '0;
          state_d = PRESENT;
        end else if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
          x_d     = 10'(X_MAX / 2);
          valid_d = 1'b1;
          retry_d = '0;
          state_d = PRESENT;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
        end
      end
      PRESENT: begin
        if (accept_c) begin
          valid_d = 1'b0;
          count_d = count_q + 8'd1;
          gap_d   = reload_c;
          state_d = enable ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spawn.spawn_valid = valid_q;
  assign spawn.spawn_x     = x_q;
  assign spawn_count       = count_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner with a spawn_x scoreboard.
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       frame_tick;
  logic [9:0] rand_in;
  logic [7:0] spawn_count;
`ifdef SPAWN_LEVEL_EN
  logic [2:0] level = 3'd0;
`endif

  obstacle_spawner_if bus ();

  obstacle_spawner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .rand_in     (rand_in),
`ifdef SPAWN_LEVEL_EN
    .level       (level),
`endif
    .spawn       (bus),
    .spawn_count (spawn_count)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  logic [7:0] exp_count;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame tick per two clocks.
  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  // Tick every cycle until spawn_valid rises or the budget runs out.
  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    frame_tick = 1'b1;
    while (!bus.spawn_valid && k < budget) begin
      step();
      k++;
    end
    frame_tick = 1'b0;
    check(tag, 32'(bus.spawn_valid), 32'd1);
  endtask

  // Accept the pending spawn against the scoreboard; reload gap with rand 5.
  task automatic accept(input string tag);
    logic [9:0] e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_x"}, 32'(bus.spawn_x), 32'(e));
    end
    rand_in = 10'd5;
    bus.spawn_ready = 1'b1;
    step();
    bus.spawn_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    check({tag, "_valid_drop"}, 32'(bus.spawn_valid), 32'd0);
    check({tag, "_count"}, 32'(spawn_count), 32'(exp_count));
  endtask

  initial begin
    rst_n           = 1'b0;
    enable          = 1'b0;
    frame_tick      = 1'b0;
    rand_in         = 10'd5;
    bus.spawn_ready = 1'b0;
    exp_count       = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_valid", 32'(bus.spawn_valid), 32'd0);
    check("rst_x", 32'(bus.spawn_x), 32'd0);
    check("rst_count", 32'(spawn_count), 32'd0);
    check("rst_gap", 32'(dut.gap_q), 32'd0);
    check("rst_retry", 32'(dut.retry_q), 32'd0);

    // Gap of 35 -> spawn after the 36th tick
    enable = 1'b1;
    step();
    check("t1_reload", 32'(dut.gap_q), 32'd35);
    exp_q.push_back(10'd5);
    send_ticks(35);
    check("t1_no_early", 32'(bus.spawn_valid), 32'd0);
    send_ticks(1);
    check("t1_valid", 32'(bus.spawn_valid), 32'd1);
    accept("t1");

    // All rejections -> fallback X_MAX/2 after the 8th
    rand_in = 10'd1000;
    send_ticks(36);
    repeat (6) step();
    check("t2_valid_after7", 32'(bus.spawn_valid), 32'd0);
    step();
    check("t2_valid_after8", 32'(bus.spawn_valid), 32'd1);
    check("t2_retry_clr", 32'(dut.retry_q), 32'd0);
    exp_q.push_back(10'd300);
    accept("t2");

    // Two rejections then an in-range draw
    send_ticks(35);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    rand_in = 10'd700;
    step();
    rand_in = 10'd650;
    step();
    check("t3_retry2", 32'(dut.retry_q), 32'd2);
    check("t3_valid_pre", 32'(bus.spawn_valid), 32'd0);
    rand_in = 10'd12;
    step();
    check("t3_valid", 32'(bus.spawn_valid), 32'd1);
    check("t3_retry_clr", 32'(dut.retry_q), 32'd0);
    exp_q.push_back(10'd12);
    accept("t3");

    // Backpressure: ticks while presenting are ignored
    rand_in = 10'd5;
    exp_q.push_back(10'd5);
    send_ticks(36);
    check("t4_valid", 32'(bus.spawn_valid), 32'd1);
    for (int i = 0; i < 200; i++) begin
      frame_tick = (i % 40 == 0);
      step();
      if (i % 50 == 49) begin
        check("t4_hold_valid", 32'(bus.spawn_valid), 32'd1);
        check("t4_hold_x", 32'(bus.spawn_x), 32'd5);
      end
    end
    check("t4_gap_frozen", 32'(dut.gap_q), 32'd0);
    frame_tick = 1'b1;
    accept("t4");
    frame_tick = 1'b0;
    check("t4_tick_ignored", 32'(dut.gap_q), 32'd35);

    // enable low mid-WAIT: no spawn
    send_ticks(10);
    check("t5_gap_mid", 32'(dut.gap_q), 32'd25);
    enable = 1'b0;
    step();
    send_ticks(40);
    check("t5_no_spawn", 32'(bus.spawn_valid), 32'd0);
    check("t5_count_same", 32'(spawn_count), 32'(exp_count));
    enable = 1'b1;
    rand_in = 10'd5;
    step();
    exp_q.push_back(10'd5);
    send_ticks(36);
    check("t5_valid", 32'(bus.spawn_valid), 32'd1);
    // enable low while presenting: no retraction, then idle
    enable = 1'b0;
    repeat (3) step();
    check("t5_no_retract", 32'(bus.spawn_valid), 32'd1);
    accept("t5");
    send_ticks(40);
    check("t5_idle_after", 32'(bus.spawn_valid), 32'd0);

    // Async reset during PRESENT with count 255
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_count = 8'd0;
    exp_q.delete();
    enable = 1'b1;
    rand_in = 10'd5;
    step();
    for (int k = 0; k < 255; k++) begin
      exp_q.push_back(10'd5);
      wait_valid("t6a_wait", 200);
      accept("t6a");
    end
    wait_valid("t6a_last_wait", 200);
    check("t6_count255", 32'(spawn_count), 32'd255);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.spawn_valid), 32'd0);
    check("t6_async_count", 32'(spawn_count), 32'd0);
    check("t6_async_x", 32'(bus.spawn_x), 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    exp_count = 8'd0;
    step();

    // 256 accepted spawns from reset wrap the counter
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(10'd5);
      wait_valid("t6b_wait", 200);
      accept("t6b");
    end
    check("t6_wrap", 32'(spawn_count), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
